// File: rtl/morph_pkg.sv
// morph_pkg: shared constants and window reduction for the 3x3 morphology filter
package morph_pkg;
  localparam int CW = 11;
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ERODE  = 2'b01;
  localparam logic [1:0] MODE_DILATE = 2'b10;
  localparam logic [1:0] MODE_GRAD   = 2'b11;
  // Bypass has no binary result; the top selects the raw centre pixel instead.
  function automatic logic morph_reduce(input logic [8:0] fg, input logic [1:0] mode);
    return mode == MODE_ERODE  ? &fg :
           mode == MODE_DILATE ? |fg :
           mode == MODE_GRAD   ? ((&fg) != (|fg)) : 1'b0;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: simple dual-port ROI line memory; reads see the pre-write contents
module line_buffer #(
  parameter int DW = 24,
  parameter int DEPTH = 200,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];
  // write port; the asynchronous read below returns old data on a same-address write
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/morph_filter3x3.sv
// morph_filter3x3: 3x3 binary erode/dilate/gradient/bypass over a raster ROI
module morph_filter3x3 import morph_pkg::*; #(
  parameter int DW = 24,
  parameter logic [CW-1:0] X_START = 11'd200,
  parameter logic [CW-1:0] Y_START = 11'd100,
  parameter logic [CW-1:0] WIDTH = 11'd200,
  parameter logic [CW-1:0] HEIGHT = 11'd200,
  parameter logic [DW-1:0] FG_VALUE = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [CW-1:0] pixel_x,
  input  logic [CW-1:0] pixel_y,
  input  logic [DW-1:0] pix_data,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic [DW-1:0] pix_out
);
  localparam int AW = $clog2(int'(WIDTH));
  logic [CW-1:0] c, r;
  logic in_roi, frame_start, row_end;
  logic [DW-1:0] l1_rd, l2_rd, row1, row2;
  logic [2:0][DW-1:0] col_in;
  logic [2:0][2:0][DW-1:0] win_q, win_d;
  logic [8:0] fg;
  logic sel_q, sel_d, frame_q, frame_d, emit1_q, emit1_d, out_valid_q, out_valid_d;
  logic [1:0] col_fill_q, col_fill_d, rows_seen_q, rows_seen_d, mode_q, mode_d;
  logic [CW-1:0] x1_q, x1_d, y1_q, y1_d, out_x_q, out_x_d, out_y_q, out_y_d;
  logic [DW-1:0] pix_out_q, pix_out_d;

  // sel_q=1 means L1 holds row r-2 (and is written), L2 holds row r-1
  line_buffer #(.DW(DW), .DEPTH(int'(WIDTH))) u_l1 (
    .clk(clk), .we(in_roi && sel_q), .wr_addr(c[AW-1:0]), .wr_data(pix_data),
    .rd_addr(c[AW-1:0]), .rd_data(l1_rd)
  );
  line_buffer #(.DW(DW), .DEPTH(int'(WIDTH))) u_l2 (
    .clk(clk), .we(in_roi && !sel_q), .wr_addr(c[AW-1:0]), .wr_data(pix_data),
    .rd_addr(c[AW-1:0]), .rd_data(l2_rd)
  );

  // ROI decode, window shift, fill counters, frame-start arming and result selection
  always_comb begin
    c = pixel_x - X_START;
    r = pixel_y - Y_START;
    in_roi = pix_en && c < WIDTH && r < HEIGHT;
    frame_start = in_roi && c == '0 && r == '0;
    row_end = in_roi && c == WIDTH - 11'd1;
    row1 = sel_q ? l2_rd : l1_rd;
    row2 = sel_q ? l1_rd : l2_rd;
    col_in = {pix_data, row1, row2};
    for (int i = 0; i < 3; i++) win_d[i] = in_roi ? {col_in[i], win_q[i][2:1]} : win_q[i];
    fg = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) fg[3*i+j] = |win_q[i][j];
    sel_d = row_end ? !sel_q : sel_q;
    frame_d = frame_q || frame_start;
    col_fill_d = !in_roi ? col_fill_q : c == '0 ? 2'd1 : col_fill_q == 2'd2 ? 2'd2 : col_fill_q + 2'd1;
    rows_seen_d = frame_start ? 2'd0 :
                  (row_end && frame_q && rows_seen_q != 2'd2) ? rows_seen_q + 2'd1 : rows_seen_q;
    mode_d = frame_start ? mode : mode_q;
    emit1_d = in_roi && c >= 11'd2 && r >= 11'd2 && col_fill_q == 2'd2 && rows_seen_q == 2'd2;
    x1_d = pixel_x - 11'd1;
    y1_d = pixel_y - 11'd1;
    out_valid_d = emit1_q;
    pix_out_d = !emit1_q ? pix_out_q :
                mode_q == MODE_BYPASS ? win_q[1][1] :
                morph_reduce(fg, mode_q) ? FG_VALUE : '0;
    out_x_d = emit1_q ? x1_q : out_x_q;
    out_y_d = emit1_q ? y1_q : out_y_q;
  end

  // pipeline registers; window and stage-1 coordinates need no reset
  always_ff @(posedge clk) begin
    win_q <= win_d;
    x1_q <= x1_d;
    y1_q <= y1_d;
    if (rst) begin
      sel_q <= 1'b0;
      frame_q <= 1'b0;
      col_fill_q <= 2'd0;
      rows_seen_q <= 2'd0;
      mode_q <= MODE_BYPASS;
      emit1_q <= 1'b0;
      out_valid_q <= 1'b0;
      pix_out_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      sel_q <= sel_d;
      frame_q <= frame_d;
      col_fill_q <= col_fill_d;
      rows_seen_q <= rows_seen_d;
      mode_q <= mode_d;
      emit1_q <= emit1_d;
      out_valid_q <= out_valid_d;
      pix_out_q <= pix_out_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_x = out_x_q;
  assign out_y = out_y_q;
  assign pix_out = pix_out_q;
endmodule
